// File: rtl/sram_axi_bridge.sv
// Uncached data-side SRAM-to-AXI3 bridge: posted writes through an in-order write buffer,
// reads stall on buffered-address hits. Define SRAM_AXI_FWD_EN for store-to-load forwarding.
module sram_axi_bridge #(
  parameter int         DATA_W     = 32,
  parameter int         WBUF_DEPTH = 4,
  parameter logic [3:0] RD_ID      = 4'h1,
  parameter logic [3:0] WR_ID      = 4'h1
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic                req_en,
  input  logic                req_wr,
  input  logic [31:0]         req_addr,
  input  logic [2:0]          req_size,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                req_stall,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                bus_err,
  output logic [3:0]          awid,
  output logic [31:0]         awaddr,
  output logic [3:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [1:0]          awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  output logic [3:0]          wid,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [3:0]          bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic [3:0]          arid,
  output logic [31:0]         araddr,
  output logic [3:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic [1:0]          arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  input  logic [3:0]          rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready
);
  localparam int SW = DATA_W / 8;
  localparam int OB = $clog2(SW);
  localparam int IW = $clog2(WBUF_DEPTH);
  localparam int PW = IW + 1;

  typedef struct packed {
    logic [31:0]       addr;
    logic [2:0]        size;
    logic [DATA_W-1:0] data;
    logic [SW-1:0]     strb;
  } wbuf_t;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wstate_t;
  typedef enum logic [2:0] {R_IDLE, R_HOLD, R_ADDR, R_DATA, R_DONE} rstate_t;

  wbuf_t         wbuf [WBUF_DEPTH];
  wbuf_t         head;
  logic [PW-1:0] wptr, rptr, count;
  logic          full, empty, push, pop;
  wstate_t       wstate, wnext;
  rstate_t       rstate, rnext;
  logic          aw_done, w_done, aw_hs, w_hs;
  logic          rd_req, hit, fwd;
  logic [DATA_W-1:0] fwd_data;
  logic [31:0]   ar_addr;
  logic [2:0]    ar_size;
  logic [WBUF_DEPTH-1:0] ent_vld, ent_hit;
  logic          unused_ok;

  assign unused_ok = ^{bid, rid};

  // ---------------- write buffer ----------------
  assign count = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (wptr[PW-1] != rptr[PW-1]) && (wptr[IW-1:0] == rptr[IW-1:0]);
  assign push  = req_en && req_wr && !full;
  assign pop   = (wstate == W_RESP) && bvalid;
  assign head  = wbuf[rptr[IW-1:0]];

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) wbuf[wptr[IW-1:0]] <= '{addr: req_addr, size: req_size, data: req_wdata, strb: req_wstrb};
  end

  // An entry is live while its distance from the head is below the occupancy.
  for (genvar g = 0; g < WBUF_DEPTH; g++) begin : g_ent
    logic [IW-1:0] ofs;
    assign ofs        = IW'(g) - rptr[IW-1:0];
    assign ent_vld[g] = {1'b0, ofs} < count;
    assign ent_hit[g] = ent_vld[g] && (wbuf[g].addr[31:OB] == req_addr[31:OB]);
  end
  assign hit = |ent_hit;

`ifdef SRAM_AXI_FWD_EN
  logic [IW-1:0] fwd_idx;
  // Walk oldest to youngest so the youngest hit wins.
  always_comb begin
    fwd      = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int k = 0; k < WBUF_DEPTH; k++) begin
      fwd_idx = rptr[IW-1:0] + IW'(k);
      if (ent_hit[fwd_idx]) begin
        fwd      = &wbuf[fwd_idx].strb;
        fwd_data = wbuf[fwd_idx].data;
      end
    end
  end
`else
  assign fwd      = 1'b0;
  assign fwd_data = '0;
`endif

  // ---------------- drain FSM ----------------
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  always_ff @(posedge clk) begin
    if (!aresetn) wstate <= W_IDLE;
    else          wstate <= wnext;
  end

  // A push into an empty buffer is visible to the head next cycle, so look ahead on it.
  always_comb begin
    wnext = wstate;
    case (wstate)
      W_IDLE:  if (!empty || push) wnext = W_ADDR;
      W_ADDR:  if ((aw_done || aw_hs) && (w_done || w_hs)) wnext = W_RESP;
      W_RESP:  if (bvalid) wnext = W_IDLE;
      default: wnext = W_IDLE;
    endcase
  end

  always_comb begin
    awvalid = (wstate == W_ADDR) && !aw_done;
    wvalid  = (wstate == W_ADDR) && !w_done;
    bready  = (wstate == W_RESP);
  end

  always_ff @(posedge clk) begin
    if (!aresetn || wstate != W_ADDR) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
    end
  end

  // ---------------- read FSM ----------------
  assign rd_req = req_en && !req_wr;

  always_ff @(posedge clk) begin
    if (!aresetn) rstate <= R_IDLE;
    else          rstate <= rnext;
  end

  always_comb begin
    rnext = rstate;
    case (rstate)
      R_IDLE:  if (rd_req) rnext = fwd ? R_DONE : (hit ? R_HOLD : R_ADDR);
      R_HOLD:  if (!hit) rnext = R_ADDR;
      R_ADDR:  if (arready) rnext = R_DATA;
      R_DATA:  if (rvalid && rlast) rnext = R_DONE;
      R_DONE:  rnext = R_IDLE;
      default: rnext = R_IDLE;
    endcase
  end

  always_comb begin
    arvalid   = (rstate == R_ADDR);
    rready    = (rstate == R_DATA);
    req_stall = 1'b0;
    if (aresetn && req_en) req_stall = req_wr ? full : (rstate != R_DONE);
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      ar_addr <= '0;
      ar_size <= '0;
    end else if (rstate == R_IDLE || rstate == R_HOLD) begin
      ar_addr <= req_addr;
      ar_size <= req_size;
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      rdata_o <= '0;
      bus_err <= 1'b0;
    end else begin
      if (rstate == R_DATA && rvalid && rlast)  rdata_o <= rdata;
      else if (rstate == R_IDLE && rd_req && fwd) rdata_o <= fwd_data;
      if ((bvalid && bready && bresp != 2'b00) || (rvalid && rready && rresp != 2'b00))
        bus_err <= 1'b1;
    end
  end

  // ---------------- AXI constants / payload ----------------
  assign awid    = WR_ID;
  assign awaddr  = head.addr;
  assign awlen   = 4'd0;
  assign awsize  = head.size;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'h0;
  assign awprot  = 3'b000;
  assign wid     = WR_ID;
  assign wdata   = head.data;
  assign wstrb   = head.strb;
  assign wlast   = 1'b1;
  assign arid    = RD_ID;
  assign araddr  = ar_addr;
  assign arlen   = 4'd0;
  assign arsize  = ar_size;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'h0;
  assign arprot  = 3'b000;
endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge with a small configurable AXI3 slave.
module tb_sram_axi_bridge;
  logic        clk = 1'b0;
  logic        aresetn;
  logic        req_en, req_wr;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic [3:0]  req_wstrb;
  logic        req_stall;
  logic [31:0] rdata_o;
  logic        bus_err;
  logic [3:0]  awid, awlen, awcache, wid, bid, arid, arlen, arcache, rid;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awsize, awprot, arsize, arprot;
  logic [1:0]  awburst, awlock, arburst, arlock, bresp, rresp;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  int n_cmp = 0, n_bad = 0;

  // slave controls and bookkeeping
  logic        aw_rdy, w_rdy, ar_rdy, r_en;
  int          b_delay;
  logic [1:0]  b_resp_cfg, r_resp_cfg;
  logic [31:0] r_data_cfg;
  int          aw_cnt, w_cnt, b_done, b_timer, ar_cnt = 0;
  logic        r_pend;
  logic [31:0] aw_log [$];

  sram_axi_bridge dut (
    .clk(clk), .aresetn(aresetn), .req_en(req_en), .req_wr(req_wr), .req_addr(req_addr),
    .req_size(req_size), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_stall(req_stall),
    .rdata_o(rdata_o), .bus_err(bus_err),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  assign awready = aw_rdy;
  assign wready  = w_rdy;
  assign arready = ar_rdy;
  assign bid     = 4'h1;
  assign rid     = 4'h1;
  assign rlast   = 1'b1;

  // B follows once both AW and W of a write have been seen, after b_delay extra cycles.
  always @(posedge clk) begin
    if (!aresetn) begin
      bvalid <= 1'b0; rvalid <= 1'b0; r_pend <= 1'b0; bresp <= 2'b00; rresp <= 2'b00; rdata <= '0;
      aw_cnt <= 0; w_cnt <= 0; b_done <= 0; b_timer <= 0;
    end else begin
      if (awvalid && awready) begin aw_cnt <= aw_cnt + 1; aw_log.push_back(awaddr); end
      if (wvalid && wready) w_cnt <= w_cnt + 1;
      if (bvalid && bready) begin
        bvalid <= 1'b0; b_done <= b_done + 1; b_timer <= 0;
      end else if (!bvalid && b_done < aw_cnt && b_done < w_cnt) begin
        if (b_timer >= b_delay) begin bvalid <= 1'b1; bresp <= b_resp_cfg; end
        else b_timer <= b_timer + 1;
      end
      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid && arready) begin
        ar_cnt <= ar_cnt + 1;
        if (r_en) begin rvalid <= 1'b1; rdata <= r_data_cfg; rresp <= r_resp_cfg; end
        else r_pend <= 1'b1;
      end else if (r_pend && r_en && !rvalid) begin
        rvalid <= 1'b1; rdata <= r_data_cfg; rresp <= r_resp_cfg; r_pend <= 1'b0;
      end
    end
  end

  task automatic push_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic stall);
    @(negedge clk);
    req_en = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d; req_wstrb = s; req_size = 3'd2;
    #1 stall = req_stall;
  endtask

  // Returns the cycle (relative to the request) at which req_stall fell, or -1 on timeout.
  task automatic run_read(input logic [31:0] a, output int cyc);
    @(negedge clk);
    req_en = 1'b1; req_wr = 1'b0; req_addr = a; req_size = 3'd2;
    cyc = 0;
    #1;
    while (req_stall && cyc < 100) begin @(negedge clk); #1; cyc++; end
    if (req_stall) cyc = -1;
    @(negedge clk); req_en = 1'b0;
  endtask

  task automatic test_reset;
    aresetn = 1'b0; req_en = 1'b1; req_wr = 1'b1; req_addr = 32'h40;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (req_stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall got=%b exp=0", req_stall); end
    n_cmp++; if (awvalid !== 1'b0) begin n_bad++; $display("FAIL rst_awvalid got=%b exp=0", awvalid); end
    n_cmp++; if (wvalid !== 1'b0) begin n_bad++; $display("FAIL rst_wvalid got=%b exp=0", wvalid); end
    n_cmp++; if (arvalid !== 1'b0) begin n_bad++; $display("FAIL rst_arvalid got=%b exp=0", arvalid); end
    n_cmp++; if ({bready, rready} !== 2'b00) begin n_bad++; $display("FAIL rst_readies got=%b exp=00", {bready, rready}); end
    n_cmp++; if (rdata_o !== 32'h0) begin n_bad++; $display("FAIL rst_rdata got=%h exp=0", rdata_o); end
    n_cmp++; if (bus_err !== 1'b0) begin n_bad++; $display("FAIL rst_buserr got=%b exp=0", bus_err); end
    @(negedge clk); req_en = 1'b0; aresetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_wbuf_full;
    logic st;
    int   t;
    aw_log.delete();
    aw_rdy = 1'b0; w_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_write(32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF, st);
      n_cmp++; if (st !== (i == 4)) begin n_bad++; $display("FAIL full_stall%0d got=%b exp=%b", i, st, (i == 4)); end
    end
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (awvalid !== 1'b1 || awaddr !== 32'h100) begin
      n_bad++; $display("FAIL aw_hold got=%b/%h exp=1/00000100", awvalid, awaddr); end
    @(negedge clk); aw_rdy = 1'b1; w_rdy = 1'b1;
    t = 0;
    #1;
    while (req_stall && t < 50) begin @(negedge clk); #1; t++; end
    n_cmp++; if (req_stall !== 1'b0) begin n_bad++; $display("FAIL full_release got=%b exp=0", req_stall); end
    @(negedge clk); req_en = 1'b0;
    t = 0;
    while (aw_log.size() < 5 && t < 200) begin @(negedge clk); t++; end
    n_cmp++; if (aw_log.size() != 5) begin n_bad++; $display("FAIL aw_count got=%0d exp=5", aw_log.size()); end
    for (int i = 0; i < 5 && i < aw_log.size(); i++) begin
      n_cmp++; if (aw_log[i] !== 32'h100 + 32'(4 * i)) begin
        n_bad++; $display("FAIL aw_order%0d got=%h exp=%h", i, aw_log[i], 32'h100 + 32'(4 * i)); end
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_read_basic;
    int ar0;
    ar0 = ar_cnt; r_data_cfg = 32'hDEADBEEF; r_resp_cfg = 2'b00;
    @(negedge clk); req_en = 1'b1; req_wr = 1'b0; req_addr = 32'h200; req_size = 3'd2;
    #1;
    n_cmp++; if (req_stall !== 1'b1 || arvalid !== 1'b0) begin
      n_bad++; $display("FAIL rd_c0 got=stall%b/ar%b exp=1/0", req_stall, arvalid); end
    @(negedge clk); #1;
    n_cmp++; if (arvalid !== 1'b1 || araddr !== 32'h200 || arsize !== 3'd2 || arlen !== 4'd0) begin
      n_bad++; $display("FAIL rd_c1 got=%b/%h/%0d exp=1/00000200/2", arvalid, araddr, arsize); end
    @(negedge clk); #1;
    n_cmp++; if (rready !== 1'b1 || req_stall !== 1'b1 || arvalid !== 1'b0) begin
      n_bad++; $display("FAIL rd_c2 got=rr%b/st%b/ar%b exp=1/1/0", rready, req_stall, arvalid); end
    @(negedge clk); #1;
    n_cmp++; if (req_stall !== 1'b0) begin n_bad++; $display("FAIL rd_c3_stall got=%b exp=0", req_stall); end
    n_cmp++; if (rdata_o !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_data got=%h exp=deadbeef", rdata_o); end
    @(negedge clk); req_en = 1'b0;
    n_cmp++; if (ar_cnt != ar0 + 1) begin n_bad++; $display("FAIL rd_ar_count got=%0d exp=%0d", ar_cnt, ar0 + 1); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_raw_hazard;
    logic st;
    int   ar0;
    b_delay = 10; r_data_cfg = 32'hCAFEF00D;
    push_write(32'h300, 32'h12345678, 4'hF, st);
    n_cmp++; if (st !== 1'b0) begin n_bad++; $display("FAIL raw_wr_stall got=%b exp=0", st); end
    ar0 = ar_cnt;
    @(negedge clk); req_wr = 1'b0; req_addr = 32'h300;
`ifdef SRAM_AXI_FWD_EN
    #1;
    n_cmp++; if (req_stall !== 1'b1) begin n_bad++; $display("FAIL fwd_c0 got=%b exp=1", req_stall); end
    @(negedge clk); #1;
    n_cmp++; if (req_stall !== 1'b0) begin n_bad++; $display("FAIL fwd_done got=%b exp=0", req_stall); end
    n_cmp++; if (rdata_o !== 32'h12345678) begin n_bad++; $display("FAIL fwd_data got=%h exp=12345678", rdata_o); end
    @(negedge clk); req_en = 1'b0;
    repeat (25) @(negedge clk);
    n_cmp++; if (ar_cnt != ar0) begin n_bad++; $display("FAIL fwd_no_ar got=%0d exp=%0d", ar_cnt, ar0); end
`else
    begin
      int cyc, b_cyc, ar_cyc;
      cyc = 0; b_cyc = -1; ar_cyc = -1;
      #1;
      while (req_stall && cyc < 80) begin
        if (bvalid && bready && b_cyc < 0) b_cyc = cyc;
        if (arvalid && ar_cyc < 0) ar_cyc = cyc;
        @(negedge clk); #1; cyc++;
      end
      n_cmp++; if (req_stall !== 1'b0) begin n_bad++; $display("FAIL raw_timeout got=%b exp=0", req_stall); end
      n_cmp++; if (b_cyc < 0 || ar_cyc != b_cyc + 2) begin
        n_bad++; $display("FAIL raw_ar_after_b got=ar@%0d b@%0d exp=ar@b+2", ar_cyc, b_cyc); end
      n_cmp++; if (rdata_o !== 32'hCAFEF00D) begin n_bad++; $display("FAIL raw_data got=%h exp=cafef00d", rdata_o); end
      @(negedge clk); req_en = 1'b0;
      n_cmp++; if (ar_cnt != ar0 + 1) begin n_bad++; $display("FAIL raw_ar_count got=%0d exp=%0d", ar_cnt, ar0 + 1); end
    end
`endif
    b_delay = 0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_bus_err;
    logic st;
    int   t, c;
    b_resp_cfg = 2'b10;
    push_write(32'h400, 32'h1, 4'hF, st);
    @(negedge clk); req_en = 1'b0;
    t = 0;
    #1;
    while (!(bvalid && bready) && t < 30) begin @(negedge clk); #1; t++; end
    n_cmp++; if (!(bvalid && bready) || bus_err !== 1'b0) begin
      n_bad++; $display("FAIL berr_pre got=hs%b/err%b exp=1/0", bvalid && bready, bus_err); end
    @(negedge clk); #1;
    n_cmp++; if (bus_err !== 1'b1) begin n_bad++; $display("FAIL berr_set got=%b exp=1", bus_err); end
    b_resp_cfg = 2'b00;
    push_write(32'h404, 32'h2, 4'hF, st);
    @(negedge clk); req_en = 1'b0;
    repeat (8) @(negedge clk);
    run_read(32'h408, c);
    n_cmp++; if (bus_err !== 1'b1 || c < 0) begin n_bad++; $display("FAIL berr_sticky got=%b/cyc%0d exp=1", bus_err, c); end
  endtask

  task automatic test_reset_mid;
    logic st;
    int   n0, t, c;
    aw_rdy = 1'b0; w_rdy = 1'b0; r_en = 1'b0;
    push_write(32'h500, 32'h5, 4'hF, st);
    push_write(32'h504, 32'h6, 4'hF, st);
    n0 = aw_log.size();
    @(negedge clk); req_wr = 1'b0; req_addr = 32'h600;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (rready !== 1'b1 || awvalid !== 1'b1) begin
      n_bad++; $display("FAIL mid_state got=rr%b/aw%b exp=1/1", rready, awvalid); end
    @(negedge clk); aresetn = 1'b0; req_en = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0) begin
      n_bad++; $display("FAIL mid_rst got=%b exp=00000", {arvalid, rready, awvalid, wvalid, bready}); end
    aresetn = 1'b1; aw_rdy = 1'b1; w_rdy = 1'b1; r_en = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++; if (aw_log.size() != n0) begin n_bad++; $display("FAIL mid_no_aw got=%0d exp=%0d", aw_log.size(), n0); end
    aw_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_write(32'h700 + 32'(4 * i), 32'h7, 4'hF, st);
      n_cmp++; if (st !== 1'b0) begin n_bad++; $display("FAIL mid_empty%0d got=%b exp=0", i, st); end
    end
    @(negedge clk); req_en = 1'b0; aw_rdy = 1'b1;
    t = 0;
    while (aw_log.size() < n0 + 4 && t < 100) begin @(negedge clk); t++; end
    n_cmp++; if (aw_log.size() < n0 + 1 || aw_log[n0] !== 32'h700) begin
      n_bad++; $display("FAIL mid_first_aw got=%h exp=00000700", aw_log.size() > n0 ? aw_log[n0] : 32'hX); end
    repeat (10) @(negedge clk);
    n_cmp++; if (bus_err !== 1'b0) begin n_bad++; $display("FAIL mid_err_clr got=%b exp=0", bus_err); end
    r_resp_cfg = 2'b10; r_data_cfg = 32'h0BAD0BAD;
    run_read(32'h800, c);
    n_cmp++; if (bus_err !== 1'b1 || rdata_o !== 32'h0BAD0BAD) begin
      n_bad++; $display("FAIL rerr got=%b/%h exp=1/0bad0bad", bus_err, rdata_o); end
    r_resp_cfg = 2'b00;
  endtask

  initial begin
    aw_rdy = 1'b1; w_rdy = 1'b1; ar_rdy = 1'b1; r_en = 1'b1; b_delay = 0;
    b_resp_cfg = 2'b00; r_resp_cfg = 2'b00; r_data_cfg = '0;
    req_en = 1'b0; req_wr = 1'b0; req_addr = '0; req_size = 3'd2; req_wdata = '0; req_wstrb = '0;
    aresetn = 1'b0;
    test_reset();
    test_wbuf_full();
    test_read_basic();
    test_raw_hazard();
    test_bus_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end
endmodule
